restoring_divider: RTL and testbench
====================================

Name: restoring_divider

Overview:
- Iterative unsigned radix-2 restoring divider. Performs the inverse of the CLA adder path: each iteration does one trial subtraction with a carry-look-ahead subtractor.
- Accepts dividend/divisor over a valid/ready request port and returns quotient/remainder over a valid/ready response port.
- Takes one iteration per clock. Sits beside the CLA adder in the arithmetic datapath.

Parameters:
- width, 8, operand, quotient and remainder width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- start_valid  input  1  request valid
- start_ready  output  1  block can accept a request
- dividend  input  width  unsigned dividend, sampled on accept
- divisor  input  width  unsigned divisor, sampled on accept
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- quotient  output  width  unsigned quotient
- remainder  output  width  unsigned remainder
- div_by_zero  output  1  set with result when divisor was 0

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: state=IDLE; quotient, remainder, div_by_zero, res_valid, iteration counter and operand registers all 0.
- start_ready = (state==IDLE), combinational from state. It reads 1 while rst is held, but inputs are ignored until rst deasserts.
- State IDLE:
  - Accept at edge E0 when start_valid && start_ready.
  - Capture divisor; load q_reg=dividend, rem_reg=0, count=width.
  - If divisor==0, go to DONE at E0. Otherwise go to RUN.
- State RUN, one iteration per edge E1..E_width:
  - shifted = {rem_reg, q_reg[width-1]} (width+1 bits).
  - trial = shifted - {1'b0, divisor}, computed by the sub-module.
  - No borrow: rem_reg = trial[width-1:0], q_reg = {q_reg[width-2:0], 1}.
  - Borrow: rem_reg = shifted[width-1:0], q_reg = {q_reg[width-2:0], 0}.
  - count decrements each iteration. On the edge where count goes 1->0, state -> DONE.
- Latency:
  - Nonzero divisor: res_valid rises in the cycle after E_width, i.e. width+1 edges after accept.
  - Zero divisor: res_valid rises the cycle after E0.
- State DONE:
  - res_valid=1; quotient=q_reg, remainder=rem_reg.
  - Outputs held stable until res_valid && res_ready at a rising edge, then state -> IDLE and res_valid -> 0 on that edge.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1. div_by_zero=0 for all other results and is cleared on return to IDLE.
- Back-pressure: with res_ready low, DONE persists indefinitely. start_valid is ignored outside IDLE; start_ready=0 throughout RUN and DONE.
- No bypass: a new request is accepted no earlier than the cycle after result handoff. Minimum throughput is one op per width+2 cycles.
- Reset mid-operation: rst in RUN or DONE returns the block to IDLE immediately. The partial result is discarded and res_valid=0 with no handoff. The next request is computed correctly from scratch.
- Arithmetic:
  - All values unsigned; no overflow is possible.
  - Invariant at DONE: dividend == quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Package divider_pkg:
  - state_e typedef enum logic [1:0] {IDLE, RUN, DONE}.
  - Function cnt_w(width) = $clog2(width+1) for sizing the iteration counter.
- Sub-module cla_subtractor #(n = width+1):
  - Ports: a[n], b[n], diff[n], borrow.
  - Computes a + ~b + 1 using per-bit generate/propagate with carry-look-ahead, carry-in=1.
  - borrow = ~carry_out.
  - Purely combinational; one instance in the iteration datapath.

Test Plan:
- 100 / 7, width=8, res_ready=1 -> res_valid exactly 9 edges after accept; quotient=14, remainder=2, div_by_zero=0.
- 5 / 9, then 255 / 1, then 0 / 5, each back-to-back -> results (0,5), (255,0), (0,0). start_ready returns 1 the cycle after each handoff.
- 37 / 0 -> res_valid 1 edge after accept; quotient=255, remainder=37, div_by_zero=1. Next op 200 / 3 -> (66,2), div_by_zero=0.
- 200 / 13 with res_ready held low 5 cycles, start_valid=1 pulsed with new operands during RUN and DONE:
  - quotient=15, remainder=5 stable all 5 cycles; start_ready=0 throughout; extra requests ignored.
  - Handoff occurs on the first res_ready=1 edge.
- Assert rst mid-RUN (iteration 4 of 200 / 13) -> state IDLE, res_valid=0, outputs 0 immediately. Next request 99 / 10 -> (9,9).
- Randomized sweep of 2000 operand pairs, including 0 and all ones, plus exhaustive check at width=4 -> invariant dividend == q*d + r, r < d, for every nonzero divisor.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // The counter must hold the value width itself, hence width+1 codes.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_cla_subtractor.sv
// Combinational n-bit subtractor a - b built as a + ~b + 1 with full carry look-ahead.
module cla_subtractor #(
  parameter int n = 9
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] diff,
  output logic         borrow
);

  logic [n-1:0] gen;
  logic [n-1:0] prop;
  logic [n:0]   carry;

  assign gen  = a & ~b;
  assign prop = a ^ ~b;

  // Carry into bit top+1 flattened as g[top] | p[top]g[top-1] | ... | p[top..0]cin, with cin = 1.
  function automatic logic carryInto(input logic [n-1:0] gv, input logic [n-1:0] pv, input int top);
    logic acc;
    logic run;
    acc = 1'b0;
    run = 1'b1;
    for (int j = top; j >= 0; j--) begin
      acc = acc | (run & gv[j]);
      run = run & pv[j];
    end
    return acc | run;
  endfunction

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < n; i++) begin : gen_carry
    assign carry[i+1] = carryInto(gen, prop, i);
  end

  assign diff   = prop ^ carry[n-1:0];
  assign borrow = ~carry[n];

endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned radix-2 restoring divider, one trial subtraction per clock,
// with valid/ready request and response handshakes.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [width-1:0] dividend,
  input  logic [width-1:0] divisor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CntW = cnt_w(width);

  state_e           state_q;
  logic [width-1:0] q_q;
  logic [width-1:0] rem_q;
  logic [width-1:0] divisor_q;
  logic [width-1:0] quotient_q;
  logic [width-1:0] remainder_q;
  logic [CntW-1:0]  count_q;
  logic             resValid_q;
  logic             divByZero_q;

  logic [width-1:0] q_d;
  logic [width-1:0] rem_d;
  logic [width:0]   shifted;
  logic [width:0]   trial;
  logic             borrow;
  logic             fits;

  assign shifted = {rem_q, q_q[width-1]};

  cla_subtractor #(
    .n(width + 1)
  ) u_sub (
    .a     (shifted),
    .b     ({1'b0, divisor_q}),
    .diff  (trial),
    .borrow(borrow)
  );

  // Without a borrow the trial is below the divisor, so its top bit is always 0.
  always_comb begin
    fits  = ~borrow & ~trial[width];
    q_d   = {q_q[width-2:0], fits};
    rem_d = fits ? trial[width-1:0] : shifted[width-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      count_q     <= '0;
      resValid_q  <= 1'b0;
      divByZero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            divisor_q <= divisor;
            q_q       <= dividend;
            rem_q     <= '0;
            count_q   <= CntW'(width);
            // A zero divisor skips the iterations and reports the fixed result directly.
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              divByZero_q <= 1'b1;
              resValid_q  <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          q_q     <= q_d;
          rem_q   <= rem_d;
          count_q <= count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            quotient_q  <= q_d;
            remainder_q <= rem_d;
            resValid_q  <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
            resValid_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = resValid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = divByZero_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed vectors, corner sequences,
// a random sweep at width 8 and an exhaustive sweep at width 4.
module tb_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       startValid, startReady, resValid, resReady, divByZero;
  logic [7:0] dividendIn, divisorIn, quotient, remainder;

  logic       startValid4, startReady4, resValid4, resReady4, divByZero4;
  logic [3:0] dividend4, divisor4, quotient4, remainder4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int dd;
    int dv;
    int q;
    int r;
    int dbz;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  restoring_divider #(.width(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .start_valid(startValid),
    .start_ready(startReady),
    .dividend   (dividendIn),
    .divisor    (divisorIn),
    .res_valid  (resValid),
    .res_ready  (resReady),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(divByZero)
  );

  restoring_divider #(.width(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .start_valid(startValid4),
    .start_ready(startReady4),
    .dividend   (dividend4),
    .divisor    (divisor4),
    .res_valid  (resValid4),
    .res_ready  (resReady4),
    .quotient   (quotient4),
    .remainder  (remainder4),
    .div_by_zero(divByZero4)
  );

  // Reference: plain integer division, with the fixed divide-by-zero answer.
  function automatic void refDiv(input int w, input int dd, input int dv,
                                 output int q, output int r, output int dbz);
    if (dv == 0) begin
      q   = (1 << w) - 1;
      r   = dd;
      dbz = 1;
    end else begin
      q   = dd / dv;
      r   = dd % dv;
      dbz = 0;
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Presents a request and returns #1 after the edge that accepts it.
  task automatic applyStimulus(input int dd, input int dv);
    int guard = 0;
    while (!startReady && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!startReady) timeoutFail("start_ready wait");
    startValid = 1'b1;
    dividendIn = dd[7:0];
    divisorIn  = dv[7:0];
    @(posedge clk); #1;
    startValid = 1'b0;
    dividendIn = 8'($urandom);
    divisorIn  = 8'($urandom);
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic waitResult(output int lat);
    lat = 1;
    while (!resValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resValid) timeoutFail("res_valid wait");
  endtask

  task automatic takeResult();
    resReady = 1'b1;
    @(posedge clk); #1;
    resReady = 1'b0;
    checkOutput("handoff res_valid", resValid, 0);
    checkOutput("handoff start_ready", startReady, 1);
  endtask

  function automatic int pick8();
    int sel = $urandom_range(0, 5);
    if (sel == 0) return 0;
    if (sel == 1) return 255;
    return $urandom_range(0, 255);
  endfunction

  task automatic runOp4(input int dd, input int dv);
    int q, r, z;
    int guard = 0;
    while (!startReady4 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!startReady4) timeoutFail("w4 start_ready wait");
    startValid4 = 1'b1;
    dividend4   = dd[3:0];
    divisor4    = dv[3:0];
    @(posedge clk); #1;
    startValid4 = 1'b0;
    guard = 0;
    while (!resValid4 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!resValid4) timeoutFail("w4 res_valid wait");
    refDiv(4, dd, dv, q, r, z);
    checkOutput("w4 quotient", quotient4, q);
    checkOutput("w4 remainder", remainder4, r);
    checkOutput("w4 div_by_zero", divByZero4, z);
    resReady4 = 1'b1;
    @(posedge clk); #1;
    resReady4 = 1'b0;
  endtask

  initial begin
    int lat, q, r, z, dd, dv;

    vecs[0] = '{100, 7, 14, 2, 0};
    vecs[1] = '{5, 9, 0, 5, 0};
    vecs[2] = '{255, 1, 255, 0, 0};
    vecs[3] = '{0, 5, 0, 0, 0};
    vecs[4] = '{37, 0, 255, 37, 1};
    vecs[5] = '{200, 3, 66, 2, 0};
    vecs[6] = '{200, 13, 15, 5, 0};
    vecs[7] = '{255, 255, 1, 0, 0};

    rst = 1'b1;
    startValid = 1'b0; resReady = 1'b0; dividendIn = '0; divisorIn = '0;
    startValid4 = 1'b0; resReady4 = 1'b0; dividend4 = '0; divisor4 = '0;

    // Reset state, and requests ignored while reset is held.
    @(posedge clk); #1;
    checkOutput("reset start_ready", startReady, 1);
    checkOutput("reset res_valid", resValid, 0);
    checkOutput("reset quotient", quotient, 0);
    checkOutput("reset remainder", remainder, 0);
    checkOutput("reset div_by_zero", divByZero, 0);
    startValid = 1'b1; dividendIn = 8'd9; divisorIn = 8'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("in-reset request ignored", startReady, 1);
    startValid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset start_ready", startReady, 1);
    checkOutput("post-reset res_valid", resValid, 0);

    // Directed vectors, back to back.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].dd, vecs[i].dv);
      waitResult(lat);
      checkOutput("vec latency", lat, (vecs[i].dbz != 0) ? 1 : 9);
      checkOutput("vec quotient", quotient, vecs[i].q);
      checkOutput("vec remainder", remainder, vecs[i].r);
      checkOutput("vec div_by_zero", divByZero, vecs[i].dbz);
      takeResult();
    end

    // Back-pressure with stray requests during RUN and DONE.
    applyStimulus(200, 13);
    for (int k = 0; k < 4; k++) begin
      startValid = 1'b1; dividendIn = 8'($urandom); divisorIn = 8'($urandom);
      checkOutput("run start_ready", startReady, 0);
      @(posedge clk); #1;
    end
    waitResult(lat);
    for (int k = 0; k < 5; k++) begin
      checkOutput("hold res_valid", resValid, 1);
      checkOutput("hold quotient", quotient, 15);
      checkOutput("hold remainder", remainder, 5);
      checkOutput("hold start_ready", startReady, 0);
      startValid = k[0]; dividendIn = 8'($urandom); divisorIn = 8'd1;
      @(posedge clk); #1;
    end
    startValid = 1'b0;
    takeResult();

    // Reset during iteration 4, then a clean operation.
    applyStimulus(200, 13);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("midrun rst start_ready", startReady, 1);
    checkOutput("midrun rst res_valid", resValid, 0);
    checkOutput("midrun rst quotient", quotient, 0);
    checkOutput("midrun rst remainder", remainder, 0);
    checkOutput("midrun rst div_by_zero", divByZero, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(99, 10);
    waitResult(lat);
    checkOutput("after rst latency", lat, 9);
    checkOutput("after rst quotient", quotient, 9);
    checkOutput("after rst remainder", remainder, 9);
    takeResult();

    // Random sweep with random result back-pressure.
    for (int n = 0; n < 2000; n++) begin
      dd = pick8();
      dv = pick8();
      applyStimulus(dd, dv);
      waitResult(lat);
      refDiv(8, dd, dv, q, r, z);
      checkOutput("rand latency", lat, (dv == 0) ? 1 : 9);
      checkOutput("rand quotient", quotient, q);
      checkOutput("rand remainder", remainder, r);
      checkOutput("rand div_by_zero", divByZero, z);
      if (dv != 0)
        checkOutput("rand invariant",
                    int'((int'(quotient) * dv + int'(remainder) == dd) && (int'(remainder) < dv)), 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      checkOutput("rand held quotient", quotient, q);
      takeResult();
    end

    // Exhaustive sweep on the 4-bit instance.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        runOp4(a, b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
